// File: rtl/clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider
// Purpose  : Free-running binary divider counter with a selectable tap and a
//            registered rising-edge tick for that tap.
// Revision : 1.0 - initial release
// ============================================================================

module clock_divider #(
    parameter int WIDTH       = 32,
    parameter int WHICH_CLOCK = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] divided_clocks,
    output logic             sel_clock,
    output logic             sel_tick
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             run;
    logic [WIDTH-1:0] count_next;
    logic             tap_next;

    // Holds counting off for the release edge so the first increment lands
    // on the second rising edge after reset_n deasserts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_comb begin
        count_next = divided_clocks;
        if (clear) begin
            count_next = '0;
        end else if (enable && run) begin
            count_next = divided_clocks + C_ONE;
        end
        tap_next = count_next[WHICH_CLOCK];
    end

    // The registered tap bit is the sel_clock history; the tick is computed
    // from the upcoming value so it aligns with the cycle the bit shows high.
    // Clear and wrap always drive the tap to 0, so they can never tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            divided_clocks <= '0;
            sel_tick       <= 1'b0;
        end else begin
            divided_clocks <= count_next;
            sel_tick       <= tap_next & ~divided_clocks[WHICH_CLOCK];
        end
    end

    assign sel_clock = divided_clocks[WHICH_CLOCK];

endmodule

`default_nettype wire

// File: tb/tb_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider
// Purpose  : Directed self-checking bench for clock_divider (several taps and
//            widths driven from one shared stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================

module tb_clock_divider;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;

    logic [31:0] dc_a;
    logic        sel_a, tick_a;
    logic [31:0] dc_b;
    logic        sel_b, tick_b;
    logic [3:0]  dc_c;
    logic        sel_c, tick_c;
    logic [3:0]  dc_d;
    logic        sel_d, tick_d;

    int checks   = 0;
    int failures = 0;

    clock_divider #(.WIDTH(32), .WHICH_CLOCK(0)) u_dut_a (
        .clock(clk), .reset_n(rst_n), .enable(en), .clear(clr),
        .divided_clocks(dc_a), .sel_clock(sel_a), .sel_tick(tick_a)
    );

    clock_divider #(.WIDTH(32), .WHICH_CLOCK(2)) u_dut_b (
        .clock(clk), .reset_n(rst_n), .enable(en), .clear(clr),
        .divided_clocks(dc_b), .sel_clock(sel_b), .sel_tick(tick_b)
    );

    clock_divider #(.WIDTH(4), .WHICH_CLOCK(3)) u_dut_c (
        .clock(clk), .reset_n(rst_n), .enable(en), .clear(clr),
        .divided_clocks(dc_c), .sel_clock(sel_c), .sel_tick(tick_c)
    );

    clock_divider #(.WIDTH(4), .WHICH_CLOCK(0)) u_dut_d (
        .clock(clk), .reset_n(rst_n), .enable(en), .clear(clr),
        .divided_clocks(dc_d), .sel_clock(sel_d), .sel_tick(tick_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // c: expected 32-bit count; inc: the last edge was a counting increment.
    task automatic check_all(input int c, input bit inc, input string ph);
        check({ph, ":a_cnt"},  64'(dc_a),   64'(c));
        check({ph, ":a_sel"},  64'(sel_a),  64'(c % 2 == 1));
        check({ph, ":a_tick"}, 64'(tick_a), 64'(inc && (c % 2 == 1)));
        check({ph, ":b_cnt"},  64'(dc_b),   64'(c));
        check({ph, ":b_sel"},  64'(sel_b),  64'((c % 8) >= 4));
        check({ph, ":b_tick"}, 64'(tick_b), 64'(inc && (c % 8 == 4)));
        check({ph, ":c_cnt"},  64'(dc_c),   64'(c % 16));
        check({ph, ":c_sel"},  64'(sel_c),  64'((c % 16) >= 8));
        check({ph, ":c_tick"}, 64'(tick_c), 64'(inc && (c % 16 == 8)));
        check({ph, ":d_cnt"},  64'(dc_d),   64'(c % 16));
        check({ph, ":d_tick"}, 64'(tick_d), 64'(inc && (c % 2 == 1)));
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;

        // Asynchronous reset must define outputs before any clock edge.
        #1 check_all(0, 1'b0, "rst0");
        repeat (2) @(negedge clk);
        check_all(0, 1'b0, "rst_hold");

        // Release between edges: release edge holds 0, then 1,2,3,...
        rst_n = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            check_all(i - 1, i > 1, "count");
        end

        // Enable low: value held, no ticks.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all(32, 1'b0, "hold");
        end
        en = 1'b1;
        for (int c = 33; c <= 41; c++) begin
            @(negedge clk);
            check_all(c, 1'b1, "resume");
        end

        // Clear with enable high wins and produces no tick.
        clr = 1'b1;
        @(negedge clk);
        check_all(0, 1'b0, "clear");
        clr = 1'b0;
        for (int c = 1; c <= 37; c++) begin
            @(negedge clk);
            check_all(c, 1'b1, "after_clr");
        end

        // Mid-count asynchronous reset between edges at count 37.
        #2 rst_n = 1'b0;
        #1 check_all(0, 1'b0, "async_rst");
        clr = 1'b1;
        @(negedge clk);
        check_all(0, 1'b0, "rst_held1");
        clr = 1'b0;
        @(negedge clk);
        check_all(0, 1'b0, "rst_held2");

        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_all(i - 1, i > 1, "restart");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
